// File: rtl/timer_ctrl.sv
// Memory-mapped timer with prescaler, compare match, one-shot/periodic modes and a
// single-outstanding request/response host port.
module timer_ctrl #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  r_enable;
   logic                  r_periodic;
   logic                  r_irq_en;
   logic                  r_expired;
   logic [31:0]           r_compare;
   logic [31:0]           r_count;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_pcnt;

   logic                  r_resp_valid;
   logic [31:0]           r_resp_rdata;
   logic                  r_resp_err;

   logic                  w_xfer;
   logic                  w_wr;
   logic [2:0]            w_sel;
   logic                  w_ctrl_wr;
   logic                  w_start;
   logic                  w_stop;
   logic                  w_cmp_wr;
   logic                  w_psc_wr;
   logic                  w_w1c;
   logic                  w_tick;
   logic                  w_hit;
   logic [31:0]           w_rdata;
   logic                  w_rerr;
   logic                  w_unused;

   assign w_unused   = ^req_addr[1:0];

   assign req_ready  = !r_resp_valid;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign irq        = r_irq_en && r_expired;

   assign w_xfer     = req_valid && req_ready;
   assign w_wr       = w_xfer && req_we;
   assign w_sel      = req_addr[4:2];
   assign w_ctrl_wr  = w_wr && (w_sel == 3'd0);
   assign w_cmp_wr   = w_wr && (w_sel == 3'd1);
   assign w_psc_wr   = w_wr && (w_sel == 3'd2);
   assign w_w1c      = w_wr && (w_sel == 3'd4) && req_wdata[0];
   assign w_start    = w_ctrl_wr && req_wdata[0] && req_wdata[3];
   assign w_stop     = w_ctrl_wr && !req_wdata[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A CTRL write overrides a same-cycle expiry so restart/stop always win.
   always_comb begin
      w_state_next = r_state;
      if (w_stop) begin
         w_state_next = IDLE;
      end else if (w_start) begin
         w_state_next = RUN;
      end else if (w_hit && !r_periodic) begin
         w_state_next = DONE;
      end
   end

   always_comb begin
      w_tick = (r_state == RUN) && (r_pcnt == r_prescale);
      w_hit  = w_tick && (r_count == r_compare);
   end

   always_comb begin
      w_rdata = '0;
      w_rerr  = 1'b0;
      case (w_sel)
         3'd0:    w_rdata[2:0]            = {r_irq_en, r_periodic, r_enable};
         3'd1:    w_rdata                 = r_compare;
         3'd2:    w_rdata[PRESCALE_W-1:0] = r_prescale;
         3'd3:    w_rdata                 = r_count;
         3'd4:    w_rdata[2:0]            = {r_state, r_expired};
         default: w_rerr                  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else if (w_xfer) begin
         r_resp_valid <= 1'b1;
         r_resp_rdata <= req_we ? '0 : w_rdata;
         r_resp_err   <= w_rerr;
      end else if (r_resp_valid && resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enable   <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_compare  <= '1;
         r_prescale <= '0;
      end else begin
         if (w_ctrl_wr) begin
            {r_irq_en, r_periodic, r_enable} <= req_wdata[2:0];
         end
         if (w_cmp_wr) begin
            r_compare <= req_wdata;
         end
         if (w_psc_wr) begin
            r_prescale <= req_wdata[PRESCALE_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_pcnt  <= '0;
      end else if (w_start) begin
         r_count <= '0;
         r_pcnt  <= '0;
      end else if (r_state == RUN) begin
         if (w_tick) begin
            r_pcnt <= '0;
            if (w_hit) begin
               if (r_periodic) begin
                  r_count <= '0;
               end
            end else begin
               r_count <= r_count + 32'd1;
            end
         end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
         end
      end
   end

   // Set has priority over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_expired <= 1'b0;
      end else begin
         r_expired <= w_hit | (r_expired & ~w_w1c);
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: cycle-level reference model compared every cycle,
// plus hand-computed expectations for the headline scenarios.
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   timer_ctrl #(.PRESCALE_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .irq        (irq)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: the timer is a countdown of cycles to the next tick,
   // state kept as the numeric codes IDLE=0, RUN=1, DONE=2.
   int unsigned m_state, m_left, m_psc;
   bit          m_en, m_per, m_ien, m_exp, m_rv, m_rerr;
   bit [31:0]   m_cmp, m_cnt, m_rdata;

   function automatic void model_step();
      bit          xfer, wr, tick, hit;
      int unsigned sel;
      if (rst) begin
         m_state = 0; m_left = 0; m_psc = 0;
         m_en = 0; m_per = 0; m_ien = 0; m_exp = 0;
         m_rv = 0; m_rerr = 0; m_rdata = 0;
         m_cmp = 32'hFFFF_FFFF; m_cnt = 0;
         return;
      end
      xfer = req_valid && !m_rv;
      wr   = xfer && req_we;
      sel  = 32'(req_addr[4:2]);
      if (m_rv && resp_ready) m_rv = 0;
      if (xfer) begin
         m_rv    = 1;
         m_rerr  = (sel > 4);
         m_rdata = 0;
         if (!req_we) begin
            case (sel)
               0: m_rdata = {29'd0, m_ien, m_per, m_en};
               1: m_rdata = m_cmp;
               2: m_rdata = m_psc;
               3: m_rdata = m_cnt;
               4: m_rdata = {29'd0, m_state[1:0], m_exp};
               default: m_rdata = 0;
            endcase
         end
      end
      tick = (m_state == 1) && (m_left == 0);
      hit  = tick && (m_cnt == m_cmp);
      if (m_state == 1) begin
         if (m_left == 0) m_left = m_psc;
         else m_left = m_left - 1;
         if (hit) begin
            m_exp = 1;
            if (m_per) m_cnt = 0;
            else m_state = 2;
         end else if (tick) begin
            m_cnt = m_cnt + 1;
         end
      end
      if (wr) begin
         case (sel)
            0: begin
               m_en = req_wdata[0]; m_per = req_wdata[1]; m_ien = req_wdata[2];
               if (!req_wdata[0]) m_state = 0;
               else if (req_wdata[3]) begin
                  m_state = 1; m_cnt = 0; m_left = m_psc;
               end
            end
            1: m_cmp = req_wdata;
            2: m_psc = 32'(req_wdata[15:0]);
            4: if (req_wdata[0] && !hit) m_exp = 0;
            default: ;
         endcase
      end
   endfunction

   always @(posedge clk or posedge rst) model_step();

   always @(negedge clk) begin
      check("req_ready", 32'(req_ready), 32'(!m_rv));
      check("resp_valid", 32'(resp_valid), 32'(m_rv));
      check("irq", 32'(irq), 32'(m_ien && m_exp));
      if (m_rv) begin
         check("resp_rdata", resp_rdata, m_rdata);
         check("resp_err", 32'(resp_err), 32'(m_rerr));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
      int unsigned n;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; resp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin step(1); n++; end
      if (!req_ready) check("bus_ready_timeout", 32'(req_ready), 1);
      step(1);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin step(1); n++; end
      if (!resp_valid) check("bus_resp_timeout", 32'(resp_valid), 1);
      rd = resp_rdata;
      er = resp_err;
      step(1);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] x;
      logic        e;
      bus(1'b1, a, d, x, e);
   endtask

   task automatic rdchk(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] x;
      logic        e;
      bus(1'b0, a, '0, x, e);
      check(name, x, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int unsigned n;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

      repeat (2) @(posedge clk);
      #2;
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", 32'(resp_err), 0);
      check("rst_irq", 32'(irq), 0);
      rst = 1'b0;
      step(1);
      rdchk("rst_compare", 5'h04, 32'hFFFF_FFFF);
      rdchk("rst_prescale", 5'h08, 0);
      rdchk("rst_status", 5'h10, 0);
      rdchk("rst_ctrl", 5'h00, 0);

      // One-shot: ticks every 4 cycles, expiry on the third tick
      wr(5'h08, 3);
      wr(5'h04, 2);
      wr(5'h00, 32'hD);
      step(10);
      check("oneshot_irq_early", 32'(irq), 0);
      step(1);
      check("oneshot_irq", 32'(irq), 1);
      rdchk("oneshot_status", 5'h10, 5);
      rdchk("oneshot_count", 5'h0C, 2);
      rdchk("oneshot_ctrl", 5'h00, 5);

      bus(1'b0, 5'h14, '0, d, e);
      check("unmapped_rdata", d, 0);
      check("unmapped_err", 32'(e), 1);
      bus(1'b1, 5'h18, 32'hFFFF_FFFF, d, e);
      check("unmapped_wr_err", 32'(e), 1);
      bus(1'b1, 5'h0C, 32'h1234, d, e);
      check("count_wr_err", 32'(e), 0);
      rdchk("count_wr_ignored", 5'h0C, 2);

      // Back-pressure: response held, second request must wait
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h04; resp_ready = 1'b0;
      step(1);
      req_we = 1'b1; req_wdata = 32'h77;
      for (int i = 0; i < 5; i++) begin
         check("hold_resp_valid", 32'(resp_valid), 1);
         check("hold_resp_rdata", resp_rdata, 2);
         check("hold_req_ready", 32'(req_ready), 0);
         step(1);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      step(1);
      check("hold_release_valid", 32'(resp_valid), 0);
      check("hold_release_ready", 32'(req_ready), 1);
      rdchk("hold_no_accept", 5'h04, 2);

      // Periodic, one expiry per 5 cycles
      wr(5'h10, 1);
      check("w1c_irq", 32'(irq), 0);
      wr(5'h08, 0);
      wr(5'h04, 4);
      wr(5'h00, 32'hF);
      n = 0;
      while (!irq && n < 20) begin step(1); n++; end
      check("periodic_irq_seen", 32'(irq), 1);
      wr(5'h10, 1);
      check("periodic_w1c_irq", 32'(irq), 0);
      step(2);
      check("periodic_before_next", 32'(irq), 0);
      step(1);
      check("periodic_next", 32'(irq), 1);
      step(4);
      wr(5'h10, 1);
      check("w1c_set_wins", 32'(irq), 1);

      // COMPARE=0, PRESCALE=0: expiry every cycle; restart from RUN
      wr(5'h04, 0);
      wr(5'h00, 32'hF);
      wr(5'h10, 1);
      rdchk("cmp0_status", 5'h10, 3);
      rdchk("cmp0_count", 5'h0C, 0);

      wr(5'h00, 0);
      rdchk("stop_status", 5'h10, 1);
      check("stop_irq", 32'(irq), 0);

      // COMPARE moved below COUNT mid-run: count keeps climbing
      wr(5'h04, 100);
      wr(5'h00, 32'hD);
      step(8);
      wr(5'h04, 3);
      rdchk("past_compare_count", 5'h0C, 11);
      rdchk("past_compare_status", 5'h10, 3);
      check("past_compare_irq", 32'(irq), 1);

      // Reset with a response pending
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h0C; resp_ready = 1'b0;
      step(1);
      req_valid = 1'b0;
      check("pre_rst_resp_valid", 32'(resp_valid), 1);
      rst = 1'b1;
      #1;
      check("midrst_resp_valid", 32'(resp_valid), 0);
      check("midrst_req_ready", 32'(req_ready), 1);
      check("midrst_resp_rdata", resp_rdata, 0);
      check("midrst_resp_err", 32'(resp_err), 0);
      check("midrst_irq", 32'(irq), 0);
      step(1);
      rst = 1'b0;
      step(1);
      rdchk("post_rst_compare", 5'h04, 32'hFFFF_FFFF);
      rdchk("post_rst_count", 5'h0C, 0);
      rdchk("post_rst_status", 5'h10, 0);
      rdchk("post_rst_prescale", 5'h08, 0);
      rdchk("post_rst_ctrl", 5'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter PRESCALE_W, default 16: width of the prescale register and the prescale counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1=write, 0=read.
REQ-007 req_addr  input  5  byte address, word-aligned; bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 resp_valid  output  1  response present.
REQ-010 resp_ready  input  1  host accepts response.
REQ-011 resp_rdata  output  32  read data; 0 for writes.
REQ-012 resp_err  output  1  unmapped address.
REQ-013 irq  output  1  level interrupt.

Function
REQ-014 Register map SHALL be: 0x00 CTRL [0]=enable, [1]=periodic, [2]=irq_en, [3]=start (write-only pulse, reads 0); 0x04 COMPARE [31:0]; 0x08 PRESCALE [PRESCALE_W-1:0]; 0x0C COUNT (read-only); 0x10 STATUS [0]=expired (write-1-to-clear), [2:1]=FSM state (read-only).
REQ-015 Request transfer SHALL occur on a cycle with req_valid && req_ready; req_ready SHALL be 1 exactly when no response is pending.
REQ-016 resp_valid SHALL assert the cycle after transfer and hold, with resp_rdata and resp_err stable, until the cycle resp_valid && resp_ready; req_ready SHALL return to 1 on the following cycle.
REQ-017 Read data SHALL reflect register contents at the transfer cycle; write side effects SHALL take effect on the cycle after transfer.
REQ-018 Unmapped address: write SHALL be ignored, read SHALL return 0, resp_err=1; writes to COUNT SHALL be ignored with resp_err=0.
REQ-019 FSM states SHALL be IDLE=0, RUN=1, DONE=2.
REQ-020 A CTRL write with start=1 and enable=1 SHALL clear COUNT and the prescale counter and enter RUN from any state, including RUN (restart).
REQ-021 In RUN, the prescale counter SHALL increment each cycle; when it equals PRESCALE it SHALL clear and generate one tick, giving one tick per PRESCALE+1 cycles.
REQ-022 On a tick with COUNT==COMPARE: expired SHALL set; periodic=1 clears COUNT and stays in RUN; periodic=0 holds COUNT and enters DONE.
REQ-023 On a tick with COUNT!=COMPARE, COUNT SHALL increment by 1 modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-024 A CTRL write with enable=0 SHALL move the FSM to IDLE, holding COUNT; DONE SHALL leave only via start or enable=0.
REQ-025 COMPARE and PRESCALE writes during RUN SHALL apply from the next cycle without restarting the count.
REQ-026 irq SHALL equal irq_en && expired, registered-free from state.
REQ-027 If a W1C of expired and a new expiry occur in the same cycle, expired SHALL remain 1 (set wins).
REQ-028 COMPARE=0 with PRESCALE=0 SHALL expire every cycle in periodic mode.

Reset
REQ-029 On rst: FSM=IDLE, CTRL=0, COMPARE=0xFFFFFFFF, PRESCALE=0, COUNT=0, prescale counter=0, expired=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, irq=0.
REQ-030 rst asserted mid-transaction or mid-count SHALL discard any pending response and return all state to reset values immediately.

Verification
REQ-031 Write PRESCALE=3, COMPARE=2, CTRL=0xD (oneshot) -> first expiry 12 cycles after start takes effect, irq=1, STATUS reads 0x5, COUNT=2 held.
REQ-032 Periodic, PRESCALE=0, COMPARE=4 -> expired sets every 5 cycles; W1C STATUS=1 clears irq until the next expiry.
REQ-033 W1C issued on the exact expiry cycle -> expired stays 1, irq stays 1.
REQ-034 resp_ready held 0 for 5 cycles after a read -> resp_valid and data stable, req_ready=0 throughout, new req_valid not accepted.
REQ-035 Read 0x14 -> resp_rdata=0, resp_err=1; write COUNT -> no change, resp_err=0.
REQ-036 During RUN write COMPARE below COUNT -> COUNT wraps through 0xFFFFFFFF to 0 then expires at new COMPARE; assert rst mid-run -> all outputs at reset values same cycle.
